regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Initiator side of the register-file write port (regWrite / writeRegister / writeData).
- Merges two result sources into the single write port:
  - the in-order pipeline writeback, which is single-cycle and has priority;
  - long-latency results (load / mult-div), which are buffered in a small FIFO.
- Exposes pending-write lookups so decode can stall on registers with writes still queued.
- Sits between the WB stage, the long-latency units and regfile.

Parameters:
- DATA_W, 32, write data width.
- REG_W, 5, register index width.
- DEPTH, 4, long-latency FIFO entries; power of two, >=2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- wbValid  input  1  pipeline writeback request this cycle.
- wbReg  input  REG_W  pipeline destination register.
- wbData  input  DATA_W  pipeline result.
- ldValid  input  1  long-latency result offered.
- ldReg  input  REG_W  long-latency destination register.
- ldData  input  DATA_W  long-latency result.
- ldReady  output  1  arbiter can accept a long-latency result.
- chkReg1  input  REG_W  decode lookup index 1.
- chkReg2  input  REG_W  decode lookup index 2.
- pending1  output  1  a queued write targets chkReg1.
- pending2  output  1  a queued write targets chkReg2.
- regWrite  output  1  to regfile write enable.
- writeRegister  output  REG_W  to regfile write index.
- writeData  output  DATA_W  to regfile write data.

Behaviour:
- Reset (async, rst=1):
  - regWrite=0, writeRegister=0, writeData=0.
  - FIFO empty, count=0, all entry valid bits cleared.
  - ldReady=1 once rst deasserts; pending1/2=0.
  - Reset mid-operation discards all queued writes; nothing is issued after reset.
- Write-port outputs are registered: a write selected in cycle N appears on regWrite/writeRegister/writeData in cycle N+1 for exactly one cycle. Regfile then commits it on that cycle's negedge.
- Selection per cycle, in priority order:
  1. wbValid=1 and wbReg!=0: issue the wb write. The FIFO does not pop.
  2. else FIFO head valid: pop the head and issue it.
  3. else ldValid & ldReady, FIFO empty, ldReg!=0: bypass the FIFO and issue directly (latency 1).
  4. else regWrite=0 next cycle.
- ldReady:
  - ldReady = (count < DEPTH), computed from registered count only.
  - A pop in the same cycle does not raise ldReady.
- Accept and queue:
  - Handshake is ldValid & ldReady.
  - An accepted ld not bypassed under rule 3 is pushed at the tail. Push and pop in the same cycle are allowed, with count unchanged.
  - Pointers wrap modulo DEPTH.
- Register 0:
  - Writes targeting register 0 are discarded and never reach regWrite.
  - A wb to reg 0 counts as no wb, so the FIFO may drain that cycle.
  - An ld to reg 0 is accepted (ldReady honoured) and dropped.
- Kill rule (ordering):
  - When a wb write is issued to register R, every valid FIFO entry with reg==R is invalidated in that cycle.
  - An ld accepted in the same cycle with ldReg==R is dropped.
  - Invalidated entries stay in the FIFO and are popped silently. A popped invalid entry produces no write; the next valid entry pops on the next cycle.
- Pending lookup:
  - pending1 = chkReg1!=0 and any valid FIFO entry has reg==chkReg1. pending2 is the same for chkReg2.
  - Both are combinational from registered FIFO state.
  - An entry is pending until the cycle in which it is popped.
- Count range 0..DEPTH; never overflows or underflows.

Optional Feature:
- Macro: REGFILE_WRITE_ARBITER_FORWARD_EN.
- When defined, add outputs fwdData1 and fwdData2 (DATA_W each).
  - Each carries the data of the youngest valid FIFO entry matching chkReg1 / chkReg2, combinationally.
  - Value is 0 when the matching pending output is 0.
- When not defined, these ports and their logic are absent. Pending outputs are unchanged either way.

Test Plan:
- Reset: assert rst mid-run with 3 entries queued -> regWrite=0 and ldReady=1 after reset; no further writes issued.
- Bypass: idle, ldValid with ldReg=8, ldData=0xDEADBEEF -> next cycle regWrite=1, writeRegister=8, writeData=0xDEADBEEF.
- Priority and queueing:
  - Stimulus: wbValid each cycle for 6 cycles (regs 1..6). During those cycles offer ld for regs 9,10,11,12,13.
  - Required:
    - wb writes appear in order.
    - ldReady drops after 4 accepted.
    - Reg 13 is held until ldReady=1.
    - Regs 9..12 then 13 drain in order once wbValid=0.
    - pending1 for chkReg1=10 stays 1 until reg 10 pops.
- Kill: queue ld reg 7 = 0x11, then wb reg 7 = 0x22 -> only 0x22 is written to reg 7; pending1 for chkReg1=7 drops the cycle after the wb write is selected.
- Reg 0: wbValid with wbReg=0 and FIFO holding reg 3 -> reg 3 is issued that cycle; ld to reg 0 accepted with no write.
- Full wrap: push/pop 10 entries through DEPTH=4 -> data is written in order, with correct pointer wrap.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results queue in a FIFO.
// Optional REGFILE_WRITE_ARBITER_FORWARD_EN adds fwdData1/fwdData2 (youngest queued data per lookup).
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbValid,
  input  logic [REG_W-1:0]  wbReg,
  input  logic [DATA_W-1:0] wbData,
  input  logic              ldValid,
  input  logic [REG_W-1:0]  ldReg,
  input  logic [DATA_W-1:0] ldData,
  output logic              ldReady,
  input  logic [REG_W-1:0]  chkReg1,
  input  logic [REG_W-1:0]  chkReg2,
  output logic              pending1,
  output logic              pending2,
  output logic              regWrite,
  output logic [REG_W-1:0]  writeRegister,
  output logic [DATA_W-1:0] writeData
`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
  ,
  output logic [DATA_W-1:0] fwdData1,
  output logic [DATA_W-1:0] fwdData2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_W-1:0]  ent_reg  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              wb_go;
  logic              fifo_empty;
  logic              head_live;
  logic              accept;
  logic              bypass;
  logic              pop;
  logic              push;

  logic              vld_p0;
  logic [REG_W-1:0]  reg_p0;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p1;
  logic [REG_W-1:0]  reg_p1;
  logic [DATA_W-1:0] data_p1;

  // Stage p0: arbitration between writeback, FIFO head and ld bypass
  always_comb begin
    wb_go      = wbValid && (wbReg != '0);
    fifo_empty = (count == '0);
    head_live  = !fifo_empty && ent_vld[head];
    ldReady    = (count < CNT_W'(DEPTH));
    accept     = ldValid && ldReady;
    bypass     = accept && !wb_go && fifo_empty && (ldReg != '0);
    // Dead (killed) heads also drain here, silently, in a wb-free cycle.
    pop        = !wb_go && !fifo_empty;
    push       = accept && !bypass && (ldReg != '0) && !(wb_go && (ldReg == wbReg));
  end

  always_comb begin
    vld_p0  = 1'b0;
    reg_p0  = '0;
    data_p0 = '0;
    if (wb_go) begin
      vld_p0  = 1'b1;
      reg_p0  = wbReg;
      data_p0 = wbData;
    end else if (head_live) begin
      vld_p0  = 1'b1;
      reg_p0  = ent_reg[head];
      data_p0 = ent_data[head];
    end else if (bypass) begin
      vld_p0  = 1'b1;
      reg_p0  = ldReg;
      data_p0 = ldData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      // A committed wb supersedes any older queued result for the same register.
      if (wb_go) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_reg[i] == wbReg) ent_vld[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[tail]  <= ldReg;
      ent_data[tail] <= ldData;
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      reg_p1  <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      reg_p1  <= reg_p0;
      data_p1 <= data_p0;
    end
  end

  assign regWrite      = vld_p1;
  assign writeRegister = reg_p1;
  assign writeData     = data_p1;

  always_comb begin
    pending1 = 1'b0;
    pending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_reg[i] == chkReg1)) pending1 = 1'b1;
      if (ent_vld[i] && (ent_reg[i] == chkReg2)) pending2 = 1'b1;
    end
    if (chkReg1 == '0) pending1 = 1'b0;
    if (chkReg2 == '0) pending2 = 1'b0;
  end

`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwdData1 = '0;
    fwdData2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[head + PTR_W'(k)] && (ent_reg[head + PTR_W'(k)] == chkReg1) && (chkReg1 != '0))
        fwdData1 = ent_data[head + PTR_W'(k)];
      if (ent_vld[head + PTR_W'(k)] && (ent_reg[head + PTR_W'(k)] == chkReg2) && (chkReg2 != '0))
        fwdData2 = ent_data[head + PTR_W'(k)];
    end
  end
`endif

endmodule
